// File: rtl/bpb_update_queue.sv
// Write-side feeder for the branch prediction buffer: queues up to two resolved
// branches per cycle and drains them in program order, one per cycle, onto the
// single BPB commit port. Optional same-cycle bypass when empty: BPB_UPDATE_BYPASS_EN.
module bpb_update_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            in_valid,
  input  logic [1:0][31:0]      in_pc,
  input  logic [1:0][32:0]      in_result,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  stall,
  output logic                  wen,
  output logic [31:0]           pc_commit,
  output logic [32:0]           destpc_commit,
  output logic [PTR_W:0]        count,
  output logic                  overflow
);

  logic [64:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             pop;
  logic             bypass;
  logic [1:0]       push_vec;
  logic [1:0]       push_num;
  logic             we0, we1;
  logic [PTR_W-1:0] wa0, wa1;
  logic [64:0]      wd0, wd1;
  logic [64:0]      head;

  // Readiness looks only at the registered occupancy; a same-cycle pop frees nothing.
  assign in_ready = (count_q <= (PTR_W+1)'(DEPTH - 2));
  assign head     = mem_q[rd_ptr_q];
  assign pop      = (count_q != '0) && !stall;
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef BPB_UPDATE_BYPASS_EN
  logic [64:0] bypass_entry;
  assign bypass       = (count_q == '0) && !flush && (|in_valid);
  assign bypass_entry = in_valid[0] ? {in_pc[0], in_result[0]} : {in_pc[1], in_result[1]};
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    wen           = 1'b0;
    pc_commit     = '0;
    destpc_commit = '0;
    if (count_q != '0) begin
      wen                        = 1'b1;
      {pc_commit, destpc_commit} = head;
    end
`ifdef BPB_UPDATE_BYPASS_EN
    else if (bypass) begin
      wen                        = 1'b1;
      {pc_commit, destpc_commit} = bypass_entry;
    end
`endif
  end

  // A bypassed entry consumed by the BPB this cycle is removed before enqueueing.
  always_comb begin
    push_vec = in_valid;
    if (bypass && !stall) begin
      push_vec = in_valid[0] ? {in_valid[1], 1'b0} : 2'b00;
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    push_num   = 2'd0;
    we0        = 1'b0;
    we1        = 1'b0;
    wa0        = wr_ptr_q;
    wa1        = wr_ptr_q + PTR_W'(1);
    wd0        = {in_pc[0], in_result[0]};
    wd1        = {in_pc[1], in_result[1]};
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if ((|in_valid) && !in_ready) begin
        overflow_d = 1'b1;
      end
      if (in_ready) begin
        case (push_vec)
          2'b01:   we0 = 1'b1;
          2'b10: begin
            we1 = 1'b1;
            wa1 = wr_ptr_q;
          end
          2'b11: begin
            we0 = 1'b1;
            we1 = 1'b1;
          end
          default: ;
        endcase
      end
      push_num = {1'b0, we0} + {1'b0, we1};
      wr_ptr_d = wr_ptr_q + PTR_W'(push_num);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + (PTR_W+1)'(push_num) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem_q[wa0] <= wd0;
    if (we1) mem_q[wa1] <= wd1;
  end

endmodule

// File: tb/tb_bpb_update_queue.sv
// Self-checking bench for bpb_update_queue: directed scenarios plus a randomized
// run compared against a queue-based reference model of the update stream.
module tb_bpb_update_queue;

  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      in_valid;
  logic [1:0][31:0] in_pc;
  logic [1:0][32:0] in_result;
  logic            in_ready;
  logic            flush;
  logic            stall;
  logic            wen;
  logic [31:0]     pc_commit;
  logic [32:0]     destpc_commit;
  logic [3:0]      count;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  logic [64:0] mq[$];
  bit          movf;

  bpb_update_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_result(in_result),
    .in_ready(in_ready), .flush(flush), .stall(stall), .wen(wen), .pc_commit(pc_commit),
    .destpc_commit(destpc_commit), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic bit model_bypass();
`ifdef BPB_UPDATE_BYPASS_EN
    return (mq.size() == 0) && !flush && (in_valid != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [64:0] exp_head();
    if (mq.size() != 0) return mq[0];
    if (model_bypass()) return in_valid[0] ? {in_pc[0], in_result[0]} : {in_pc[1], in_result[1]};
    return '0;
  endfunction

  // Advances one clock edge and applies the same edge to the reference queue.
  task automatic tick();
    int          cnt = mq.size();
    bit          rdy = (DEPTH - cnt) >= 2;
    logic [64:0] ent[$];
    if (in_valid[0]) ent.push_back({in_pc[0], in_result[0]});
    if (in_valid[1]) ent.push_back({in_pc[1], in_result[1]});
    if (flush) begin
      mq.delete();
    end else begin
      if (model_bypass() && !stall) void'(ent.pop_front());
      if (cnt != 0 && !stall) void'(mq.pop_front());
      if (rdy) begin
        foreach (ent[k]) mq.push_back(ent[k]);
      end else if (in_valid != 2'b00) begin
        movf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] v, input logic [31:0] p0, input logic [32:0] r0,
                        input logic [31:0] p1, input logic [32:0] r1);
    in_valid     = v;
    in_pc[0]     = p0;
    in_result[0] = r0;
    in_pc[1]     = p1;
    in_result[1] = r1;
  endtask

  task automatic do_reset();
    set_in(2'b00, 0, 0, 0, 0);
    flush = 1'b0;
    stall = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    movf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end checks++;
    if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b exp 0", wen); end checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready); end checks++;
    stall = 1'b1;
    set_in(2'b11, 32'h10, 33'h1_0000_0020, 32'h14, 33'h0_0000_0024);
    tick();
    set_in(2'b01, 32'h18, 33'h1_0000_0028, 0, 0);
    tick();
    set_in(2'b00, 0, 0, 0, 0);
    if (count !== 4'd3) begin errors++; $display("FAIL premid_count got %0d exp 3", count); end checks++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    if (count !== 4'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", count); end checks++;
    if (wen !== 1'b0) begin errors++; $display("FAIL mid_reset_wen got %0b exp 0", wen); end checks++;
    if (pc_commit !== 32'h0) begin errors++; $display("FAIL mid_reset_pc got %h exp 0", pc_commit); end checks++;
    if (destpc_commit !== 33'h0) begin errors++; $display("FAIL mid_reset_dest got %h exp 0", destpc_commit); end checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_ovf got %0b exp 0", overflow); end checks++;
    reset = 1'b0;
    mq.delete();
    movf = 1'b0;
  endtask

  task automatic test_dual_push();
    do_reset();
    set_in(2'b11, 32'h1000, {1'b1, 32'h2000}, 32'h1008, {1'b0, 32'h3000});
    tick();
    set_in(2'b00, 0, 0, 0, 0);
    if (wen !== 1'b1) begin errors++; $display("FAIL dual_wen1 got %0b exp 1", wen); end checks++;
    if (pc_commit !== 32'h1000) begin errors++; $display("FAIL dual_pc1 got %h exp 1000", pc_commit); end checks++;
    if (destpc_commit !== {1'b1, 32'h2000}) begin errors++; $display("FAIL dual_dest1 got %h exp 1_00002000", destpc_commit); end checks++;
    tick();
    if (pc_commit !== 32'h1008) begin errors++; $display("FAIL dual_pc2 got %h exp 1008", pc_commit); end checks++;
    if (destpc_commit[32] !== 1'b0) begin errors++; $display("FAIL dual_taken2 got %0b exp 0", destpc_commit[32]); end checks++;
    tick();
    if (wen !== 1'b0) begin errors++; $display("FAIL dual_wen3 got %0b exp 0", wen); end checks++;
  endtask

  task automatic test_slot1_compaction();
    do_reset();
    stall = 1'b1;
    set_in(2'b10, 32'hdead, 33'h0, 32'h4000, {1'b1, 32'h4444});
    tick();
    set_in(2'b00, 0, 0, 0, 0);
    if (pc_commit !== 32'h4000) begin errors++; $display("FAIL compact_pc got %h exp 4000", pc_commit); end checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL compact_count got %0d exp 1", count); end checks++;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_in(2'b11, 32'h100 + 8*k, {1'b0, 32'h900 + 8*k}, 32'h104 + 8*k, {1'b1, 32'h904 + 8*k});
      tick();
    end
    set_in(2'b01, 32'hbad0, 33'h0, 0, 0);
    if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", in_ready); end checks++;
    tick();
    set_in(2'b00, 0, 0, 0, 0);
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow); end checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", count); end checks++;
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (wen !== 1'b1 || pc_commit !== 32'h100 + 4*i) begin
        errors++; $display("FAIL drain_%0d got wen=%0b pc=%h exp pc=%h", i, wen, pc_commit, 32'h100 + 4*i);
      end
      checks++;
      tick();
    end
    if (wen !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b exp 0", wen); end checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end checks++;
  endtask

  task automatic test_push_pop_at6();
    do_reset();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(2'b11, 32'h200 + 8*k, 33'h0, 32'h204 + 8*k, 33'h0);
      tick();
    end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL at6_ready got %0b exp 1", in_ready); end checks++;
    stall = 1'b0;
    set_in(2'b11, 32'h218, 33'h0, 32'h21c, 33'h0);
    tick();
    set_in(2'b00, 0, 0, 0, 0);
    stall = 1'b1;
    if (count !== 4'd7) begin errors++; $display("FAIL at6_count got %0d exp 7", count); end checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL at7_ready got %0b exp 0", in_ready); end checks++;
    if (pc_commit !== 32'h204) begin errors++; $display("FAIL at6_head got %h exp 204", pc_commit); end checks++;
  endtask

  task automatic test_flush();
    do_reset();
    stall = 1'b1;
    set_in(2'b11, 32'h600, 33'h0, 32'h604, 33'h0);
    tick();
    set_in(2'b01, 32'h608, 33'h0, 0, 0);
    tick();
    stall = 1'b0;
    flush = 1'b1;
    set_in(2'b11, 32'h700, 33'h0, 32'h704, 33'h0);
    #1;
    if (wen !== 1'b1 || pc_commit !== 32'h600) begin errors++; $display("FAIL flush_prehead got wen=%0b pc=%h exp 1/600", wen, pc_commit); end checks++;
    tick();
    flush = 1'b0;
    set_in(2'b00, 0, 0, 0, 0);
    if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end checks++;
    if (wen !== 1'b0) begin errors++; $display("FAIL flush_wen got %0b exp 0", wen); end checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got %0b exp 0", overflow); end checks++;
`ifdef BPB_UPDATE_BYPASS_EN
    set_in(2'b01, 32'h5000, {1'b1, 32'h5100}, 0, 0);
    #1;
    if (wen !== 1'b1 || pc_commit !== 32'h5000) begin errors++; $display("FAIL bypass_same got wen=%0b pc=%h exp 1/5000", wen, pc_commit); end checks++;
    tick();
    set_in(2'b00, 0, 0, 0, 0);
    if (count !== 4'd0) begin errors++; $display("FAIL bypass_count got %0d exp 0", count); end checks++;
`endif
  endtask

  task automatic test_random();
    logic [64:0] eh;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in(2'($urandom_range(0, 3)), $urandom, {1'($urandom), $urandom},
             $urandom, {1'($urandom), $urandom});
      stall = ((i / 100) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 40) == 0);
      #1;
      eh = exp_head();
      if (wen !== ((mq.size() != 0) || model_bypass())) begin
        errors++; $display("FAIL rnd_wen cycle %0d got %0b exp %0b", i, wen, (mq.size() != 0) || model_bypass());
      end
      checks++;
      if ({pc_commit, destpc_commit} !== eh) begin
        errors++; $display("FAIL rnd_head cycle %0d got %h exp %h", i, {pc_commit, destpc_commit}, eh);
      end
      checks++;
      if (count !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count cycle %0d got %0d exp %0d", i, count, mq.size()); end
      checks++;
      if (in_ready !== ((DEPTH - mq.size()) >= 2)) begin errors++; $display("FAIL rnd_ready cycle %0d got %0b", i, in_ready); end
      checks++;
      if (overflow !== movf) begin errors++; $display("FAIL rnd_ovf cycle %0d got %0b exp %0b", i, overflow, movf); end
      checks++;
      tick();
    end
    set_in(2'b00, 0, 0, 0, 0);
    flush = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(2'b00, 0, 0, 0, 0);
    flush = 1'b0;
    stall = 1'b0;
    test_reset();
    test_dual_push();
    test_slot1_compaction();
    test_fill_overflow();
    test_push_pop_at6();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
